// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master round-robin arbiter and address decoder for the
//               shared system bus. Define ARB_TIMEOUT_EN to abort stalled
//               slave accesses after TIMEOUT bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_M0_REQ,
    input  logic        i_M1_REQ,
    input  logic [31:0] i_M0_ADDR,
    input  logic [31:0] i_M1_ADDR,
    input  logic [31:0] i_M0_WDATA,
    input  logic [31:0] i_M1_WDATA,
    input  logic        i_M0_WE,
    input  logic        i_M0_RE,
    input  logic        i_M1_WE,
    input  logic        i_M1_RE,
    input  logic [1:0]  i_M0_HB,
    input  logic [1:0]  i_M1_HB,
    output logic        o_M0_GNT,
    output logic        o_M1_GNT,
    output logic [31:0] o_M0_RDATA,
    output logic [31:0] o_M1_RDATA,
    output logic        o_M0_ERR,
    output logic        o_M1_ERR,
    output logic [31:0] o_BUS_ADDR,
    output logic [31:0] o_BUS_WDATA,
    output logic        o_BUS_WE,
    output logic        o_BUS_RE,
    output logic        o_BUS_REQ,
    output logic [1:0]  o_BUS_HB,
    output logic [7:0]  o_BUS_CE,
    input  logic [31:0] i_BUS_RDATA,
    input  logic        i_BUS_GNT,
    output logic [31:0] o_ERR_ADDR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;       // 0 = M0, 1 = M1
    logic        last_q;
    logic [31:0] err_addr_q;

    logic        w_any_req;
    logic        w_pick;
    logic [31:0] w_pick_addr;
    logic        w_pick_mapped;
    logic [31:0] w_own_addr;
    logic [7:0]  w_ce;
    logic        w_timeout;

    assign w_any_req     = i_M0_REQ | i_M1_REQ;
    // On a tie the master that did not own the last transaction wins.
    assign w_pick        = (i_M0_REQ & i_M1_REQ) ? ~last_q : i_M1_REQ;
    assign w_pick_addr   = w_pick ? i_M1_ADDR : i_M0_ADDR;
    assign w_pick_mapped = (w_pick_addr[31:28] >= 4'h8) && (w_pick_addr[31:28] <= 4'hC);
    assign w_own_addr    = owner_q ? i_M1_ADDR : i_M0_ADDR;
    assign o_ERR_ADDR    = err_addr_q;

    always_comb begin
        case (w_own_addr[31:28])
            4'h8:    w_ce = 8'h01;
            4'h9:    w_ce = 8'h02;
            4'hA:    w_ce = 8'h04;
            4'hB:    w_ce = 8'h08;
            4'hC:    w_ce = 8'h10;
            default: w_ce = 8'h00;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    assign w_timeout = (cnt_q == 8'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            err_addr_q <= 32'h0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= 8'h0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        owner_q <= w_pick;
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= 8'h0;
`endif
                        if (w_pick_mapped) begin
                            state_q <= S_BUSY;
                        end else begin
                            state_q    <= S_ERR;
                            err_addr_q <= w_pick_addr;
                        end
                    end
                end
                S_BUSY: begin
                    if (i_BUS_GNT) begin
                        state_q <= S_IDLE;
                        last_q  <= owner_q;
                    end else if (w_timeout) begin
                        state_q    <= S_ERR;
                        err_addr_q <= w_own_addr;
                    end
`ifdef ARB_TIMEOUT_EN
                    if (!i_BUS_GNT && !w_timeout) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    last_q  <= owner_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock.
    always_comb begin
        o_M0_GNT    = 1'b0;
        o_M1_GNT    = 1'b0;
        o_M0_ERR    = 1'b0;
        o_M1_ERR    = 1'b0;
        o_M0_RDATA  = 32'h0;
        o_M1_RDATA  = 32'h0;
        o_BUS_ADDR  = 32'h0;
        o_BUS_WDATA = 32'h0;
        o_BUS_WE    = 1'b0;
        o_BUS_RE    = 1'b0;
        o_BUS_REQ   = 1'b0;
        o_BUS_HB    = 2'b00;
        o_BUS_CE    = 8'h00;
        case (state_q)
            S_BUSY: begin
                o_BUS_REQ   = 1'b1;
                o_BUS_CE    = w_ce;
                o_BUS_ADDR  = {4'h0, w_own_addr[27:0]};
                o_BUS_WDATA = owner_q ? i_M1_WDATA : i_M0_WDATA;
                o_BUS_WE    = owner_q ? i_M1_WE : i_M0_WE;
                o_BUS_RE    = owner_q ? i_M1_RE : i_M0_RE;
                o_BUS_HB    = owner_q ? i_M1_HB : i_M0_HB;
                if (owner_q) begin
                    o_M1_GNT   = i_BUS_GNT;
                    o_M1_RDATA = i_BUS_GNT ? i_BUS_RDATA : 32'h0;
                end else begin
                    o_M0_GNT   = i_BUS_GNT;
                    o_M0_RDATA = i_BUS_GNT ? i_BUS_RDATA : 32'h0;
                end
            end
            S_ERR: begin
                if (owner_q) begin
                    o_M1_GNT = 1'b1;
                    o_M1_ERR = 1'b1;
                end else begin
                    o_M0_GNT = 1'b1;
                    o_M0_ERR = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter: directed scenarios with
//               literal expectations plus randomized traffic against a
//               transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req, we, re;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  hb [2];
    logic [31:0] bus_rdata;
    logic        bus_gnt;

    logic [1:0]        gnt_o, err_o;
    logic [1:0][31:0]  rd_o;
    logic [31:0] b_addr, b_wdata, err_addr_o;
    logic        b_we, b_re, b_req;
    logic [1:0]  b_hb;
    logic [7:0]  b_ce;

    bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_M0_REQ(req[0]), .i_M1_REQ(req[1]),
        .i_M0_ADDR(addr[0]), .i_M1_ADDR(addr[1]),
        .i_M0_WDATA(wdata[0]), .i_M1_WDATA(wdata[1]),
        .i_M0_WE(we[0]), .i_M0_RE(re[0]), .i_M1_WE(we[1]), .i_M1_RE(re[1]),
        .i_M0_HB(hb[0]), .i_M1_HB(hb[1]),
        .o_M0_GNT(gnt_o[0]), .o_M1_GNT(gnt_o[1]),
        .o_M0_RDATA(rd_o[0]), .o_M1_RDATA(rd_o[1]),
        .o_M0_ERR(err_o[0]), .o_M1_ERR(err_o[1]),
        .o_BUS_ADDR(b_addr), .o_BUS_WDATA(b_wdata),
        .o_BUS_WE(b_we), .o_BUS_RE(b_re), .o_BUS_REQ(b_req),
        .o_BUS_HB(b_hb), .o_BUS_CE(b_ce),
        .i_BUS_RDATA(bus_rdata), .i_BUS_GNT(bus_gnt),
        .o_ERR_ADDR(err_addr_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: which master owns the current transaction,
    // whether it is an error response, and who completed last.
    int          cur, n_cur;
    bit          cur_err, n_err;
    int          last, n_last;
    int          waited, n_waited;
    logic [31:0] eaddr_m, n_eaddr;

    logic [1:0]  e_gnt, e_err;
    logic [31:0] e_rd [2];

    function automatic bit mapped(input logic [3:0] nib);
        return (nib >= 4'h8) && (nib <= 4'hC);
    endfunction

    task automatic model_reset();
        cur = -1; cur_err = 0; last = 1; waited = 0; eaddr_m = 32'h0;
        n_cur = -1; n_err = 0; n_last = 1; n_waited = 0; n_eaddr = 32'h0;
        e_gnt = 2'b00; e_err = 2'b00;
    endtask

    // Sample at the falling edge: derive the expected outputs and next model state.
    task automatic settle();
        logic        e_breq, e_bwe, e_bre;
        logic [7:0]  e_bce;
        logic [31:0] e_baddr, e_bwd;
        logic [1:0]  e_bhb;
        int          p, nib;
        @(negedge clk);
        e_gnt = 2'b00; e_err = 2'b00; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
        e_breq = 0; e_bwe = 0; e_bre = 0; e_bce = 8'h0;
        e_baddr = 32'h0; e_bwd = 32'h0; e_bhb = 2'b00;
        n_cur = cur; n_err = cur_err; n_last = last; n_waited = waited; n_eaddr = eaddr_m;
        if (cur < 0) begin
            if (req != 2'b00) begin
                p = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
                n_cur = p;
                n_waited = 0;
                n_err = !mapped(addr[p][31:28]);
                if (n_err) n_eaddr = addr[p];
            end
        end else if (cur_err) begin
            e_gnt[cur] = 1'b1;
            e_err[cur] = 1'b1;
            n_cur = -1; n_err = 0; n_last = cur;
        end else begin
            nib     = int'(addr[cur][31:28]);
            e_breq  = 1'b1;
            e_bce   = 8'(1 << (nib - 8));
            e_baddr = addr[cur] & 32'h0FFF_FFFF;
            e_bwd   = wdata[cur];
            e_bwe   = we[cur];
            e_bre   = re[cur];
            e_bhb   = hb[cur];
            if (bus_gnt) begin
                e_gnt[cur] = 1'b1;
                e_rd[cur]  = bus_rdata;
                n_cur = -1; n_last = cur;
            end
`ifdef ARB_TIMEOUT_EN
            else if (waited == TIMEOUT - 1) begin
                n_err = 1; n_eaddr = addr[cur];
            end else begin
                n_waited = waited + 1;
            end
`endif
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt%0d", i), 32'(gnt_o[i]), 32'(e_gnt[i]));
            chk($sformatf("err%0d", i), 32'(err_o[i]), 32'(e_err[i]));
            if (e_gnt[i] || i != cur) chk($sformatf("rdata%0d", i), rd_o[i], e_rd[i]);
        end
        chk("bus_req", 32'(b_req), 32'(e_breq));
        chk("bus_ce", 32'(b_ce), 32'(e_bce));
        chk("err_addr", err_addr_o, eaddr_m);
        if (!(cur >= 0 && cur_err)) begin
            chk("bus_addr", b_addr, e_baddr);
            chk("bus_wdata", b_wdata, e_bwd);
            chk("bus_we", 32'(b_we), 32'(e_bwe));
            chk("bus_re", 32'(b_re), 32'(e_bre));
            chk("bus_hb", 32'(b_hb), 32'(e_bhb));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        cur = n_cur; cur_err = n_err; last = n_last; waited = n_waited; eaddr_m = n_eaddr;
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w);
        req[i] = 1'b1; addr[i] = a; wdata[i] = $urandom; we[i] = w; re[i] = !w;
        hb[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic rand_req(input int i);
        int r, nib;
        r = $urandom_range(0, 9);
        nib = (r < 8) ? 8 + (r % 5) : $urandom_range(0, 15);
        set_req(i, {4'(nib), 28'($urandom)}, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int cnt;
        bit seen;
        req = 2'b00; we = 2'b00; re = 2'b00;
        for (int i = 0; i < 2; i++) begin addr[i] = 0; wdata[i] = 0; hb[i] = 0; end
        bus_rdata = 0; bus_gnt = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #2;
        chk("rst_bus_req", 32'(b_req), 32'h0);
        chk("rst_bus_ce", 32'(b_ce), 32'h0);
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_err_addr", err_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // M0 read of SRAM, zero-wait grant
        set_req(0, 32'h9000_0010, 1'b0);
        bus_gnt = 1'b1; bus_rdata = 32'h1234_5678;
        settle(); adv();
        settle();
        chk("sram_ce", 32'(b_ce), 32'h02);
        chk("sram_addr", b_addr, 32'h0000_0010);
        chk("sram_gnt", 32'(gnt_o[0]), 32'h1);
        chk("sram_rdata", rd_o[0], 32'h1234_5678);
        chk("sram_err", 32'(err_o[0]), 32'h0);
        adv(); req[0] = 1'b0;
        settle(); adv();

        // M1 write to unmapped region
        set_req(1, 32'h3000_0000, 1'b1);
        settle(); adv();
        settle();
        chk("dec_bus_req", 32'(b_req), 32'h0);
        chk("dec_gnt", 32'(gnt_o[1]), 32'h1);
        chk("dec_err", 32'(err_o[1]), 32'h1);
        chk("dec_err_addr", err_addr_o, 32'h3000_0000);
        adv(); req[1] = 1'b0;

        // Ties: last owner is M1, so M0, then M1, then M0
        set_req(0, 32'h8000_0100, 1'b0);
        set_req(1, 32'hC000_0200, 1'b1);
        bus_gnt = 1'b1;
        settle(); adv();
        settle(); chk("tie1_m0", 32'(gnt_o), 32'h1);
        adv(); set_req(0, 32'h9000_0004, 1'b0);
        settle(); adv();
        settle(); chk("tie2_m1", 32'(gnt_o), 32'h2);
        adv(); req[1] = 1'b0;
        settle(); adv();
        settle(); chk("tie3_m0", 32'(gnt_o), 32'h1);
        adv(); req[0] = 1'b0;

        // Three wait states; M1 arrives mid-transaction and is served next
        set_req(0, 32'hA000_0008, 1'b0);
        bus_gnt = 1'b0;
        settle(); adv();
        settle(); adv();
        set_req(1, 32'hB000_0000, 1'b0);
        settle(); adv();
        settle(); adv();
        bus_gnt = 1'b1; bus_rdata = 32'hCAFE_0001;
        settle();
        chk("wait_m0_gnt", 32'(gnt_o), 32'h1);
        chk("wait_m0_rdata", rd_o[0], 32'hCAFE_0001);
        adv(); req[0] = 1'b0;
        settle(); adv();
        settle(); chk("wait_m1_gnt", 32'(gnt_o), 32'h2);
        adv(); req[1] = 1'b0;

        // Asynchronous reset in the middle of a BUSY cycle
        set_req(0, 32'h8000_0000, 1'b1);
        bus_gnt = 1'b0;
        settle(); adv();
        settle();
        chk("busy_before_rst", 32'(b_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bus_req", 32'(b_req), 32'h0);
        chk("midrst_bus_ce", 32'(b_ce), 32'h0);
        chk("midrst_gnt", 32'(gnt_o), 32'h0);
        model_reset();
        req[0] = 1'b0;
        adv();
        rst_n = 1'b1;
        set_req(0, 32'h9000_0020, 1'b0);
        set_req(1, 32'hA000_0020, 1'b1);
        bus_gnt = 1'b1;
        settle(); adv();
        settle(); chk("post_rst_m0_first", 32'(gnt_o), 32'h1);
        adv(); req[0] = 1'b0;
        settle(); adv();
        settle(); chk("post_rst_m1", 32'(gnt_o), 32'h2);
        adv(); req[1] = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Slave never grants: abort after TIMEOUT cycles of request
        set_req(0, 32'hB000_0000, 1'b0);
        bus_gnt = 1'b0;
        settle(); adv();
        cnt = 0; seen = 0;
        for (int k = 0; k < 4 * TIMEOUT && !seen; k++) begin
            settle();
            if (b_req) cnt++;
            if (gnt_o[0]) begin
                seen = 1;
                chk("to_err", 32'(err_o[0]), 32'h1);
                chk("to_rdata", rd_o[0], 32'h0);
                chk("to_err_addr", err_addr_o, 32'hB000_0000);
            end
            adv();
        end
        chk("to_seen", 32'(seen), 32'h1);
        chk("to_req_cycles", 32'(cnt), 32'(TIMEOUT));
        req[0] = 1'b0;
        settle(); adv();
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (e_gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) rand_req(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 4) < 2) begin
                    rand_req(i);
                end
            end
            bus_gnt = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            settle();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and address decoder for the shared system bus. It sits between the core data port (M0) and a second bus master such as a DMA or debug port (M1) on one side, and the ROM, SRAM, UART, timer and GPIO slaves on the other. It serialises their REQ/GNT transactions with round-robin fairness and generates the one-hot slave chip-enables. It also terminates accesses to unmapped addresses, and optionally stalled ones, with an error response.

## Interface
Parameters:
- TIMEOUT, 16: bus cycles allowed for slave GNT before abort (only with ARB_TIMEOUT_EN); range 2..255.

Ports:
- i_CLK  in  1  system clock; single clock domain.
- i_RSTn  in  1  reset, asynchronous, active-low.
- i_M0_REQ, i_M1_REQ  in  1 each  master request; held stable with all request fields until the matching GNT.
- i_M0_ADDR, i_M1_ADDR  in  32 each  byte address; bits [31:28] select the slave.
- i_M0_WDATA, i_M1_WDATA  in  32 each  write data.
- i_M0_WE, i_M0_RE, i_M1_WE, i_M1_RE  in  1 each  write / read strobe.
- i_M0_HB, i_M1_HB  in  2 each  access size code, passed through unchanged.
- o_M0_GNT, o_M1_GNT  out  1 each  one-cycle completion pulse to the owning master.
- o_M0_RDATA, o_M1_RDATA  out  32 each  read data, valid while the matching GNT is high.
- o_M0_ERR, o_M1_ERR  out  1 each  high with GNT when the access ended in error.
- o_BUS_ADDR  out  32  {4'h0, owner ADDR[27:0]}.
- o_BUS_WDATA  out  32  write data routed to the slaves.
- o_BUS_WE, o_BUS_RE, o_BUS_REQ  out  1 each  write strobe, read strobe and request to the slaves.
- o_BUS_HB  out  2  access size code to the slaves.
- o_BUS_CE  out  8  one-hot slave select.
- i_BUS_RDATA  in  32  read data from the selected slave.
- i_BUS_GNT  in  1  completion from the selected slave.
- o_ERR_ADDR  out  32  full address of the most recent errored access.

## Operation
- FSM states: IDLE, BUSY, ERR.
- IDLE:
  - If any REQ is high, pick the owner.
  - With both REQs high, pick the master that was not the last owner.
  - After reset the last owner is M1, so M0 wins the first tie.
  - If the owner's ADDR[31:28] is in 8..C, go to BUSY; otherwise go to ERR.
- Decode map:
  - 8 → CE[0] ROM.
  - 9 → CE[1] SRAM.
  - A → CE[2] UART.
  - B → CE[3] timer.
  - C → CE[4] GPIO.
  - CE[7:5] stay 0.
- BUSY:
  - Drive o_BUS_* from the owner's live inputs: o_BUS_REQ=1, o_BUS_CE=decoded one-hot, o_BUS_WE/RE gated by ownership.
  - When i_BUS_GNT=1: pulse the owner's GNT, set owner RDATA=i_BUS_RDATA, ERR=0, update last owner, go to IDLE.
- ERR (one cycle):
  - o_BUS_REQ=0 and o_BUS_CE=0.
  - Owner GNT=1, ERR=1, RDATA=32'h0.
  - o_ERR_ADDR captures the owner's address.
  - Update last owner, go to IDLE.
- Non-owner GNT/ERR are always 0, and non-owner RDATA is 0.
- IDLE outputs: all o_BUS_* and o_BUS_CE are 0.

## Timing
- Reset values: state IDLE, every output 0, last owner M1, timeout counter 0.
- Latency for a mapped access with a zero-wait slave:
  - REQ seen in IDLE at cycle 0.
  - BUSY at cycle 1; i_BUS_GNT is combinational in that cycle, so master GNT fires in cycle 1.
  - IDLE again at cycle 2.
- A decode error produces GNT+ERR in cycle 1.
- At least one IDLE cycle separates consecutive transactions.
- A request that arrives while another master is BUSY waits; it is not lost.
- Slave wait states extend BUSY with no limit unless the timeout is enabled.
- Asserting i_RSTn low mid-transaction returns to IDLE immediately, drops o_BUS_REQ/CE asynchronously and emits no GNT.
- i_BUS_GNT seen outside BUSY is ignored.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without i_BUS_GNT.
  - When the count reaches TIMEOUT-1 with i_BUS_GNT still low, the next state is ERR: the abort response follows in the next cycle and o_BUS_REQ drops.
  - If i_BUS_GNT and the counter limit occur in the same cycle, GNT wins and the access completes normally.
- Undefined: no counter is built, and BUSY waits for i_BUS_GNT indefinitely.

## Test plan
- M0 reads 0x9000_0010, SRAM grants in the same cycle with RDATA 0x1234_5678 → o_BUS_CE=0x02 and o_BUS_ADDR=0x0000_0010 in cycle 1; o_M0_GNT pulse with RDATA 0x1234_5678, ERR=0.
- M0 and M1 both request in the same cycle after reset, then both again → M0 served first, M1 second, M0 third; each GNT is a single-cycle pulse.
- M1 writes 0x3000_0000 → no o_BUS_REQ; o_M1_GNT=1 and o_M1_ERR=1 in cycle 1; o_ERR_ADDR=0x3000_0000.
- With ARB_TIMEOUT_EN and TIMEOUT=16, M0 reads 0xB000_0000 and the slave never grants → o_BUS_REQ high for exactly 16 cycles, then GNT+ERR with RDATA 0.
- Slave grants after 3 wait cycles → master GNT fires on the 4th BUSY cycle; M1, which requested mid-transaction, is granted afterwards.
- i_RSTn pulsed low during BUSY → all outputs 0 within the same cycle, no GNT, arbiter in IDLE and M0 preferred after release.
